control_sequencer: RTL

- Hardwired control unit that replaces hand-driven test sequencing.
- Steps fetch (T0–T2) and execute (T3–T7) for every ISA opcode.
- Drives the datapath control inputs and reads back IR and the CON branch flag.
- Sits beside datapath in the top level; its outputs drive the datapath's control ports one-for-one.

---
 rtl/cpu_defs_pkg.sv | 62 ++++++
 rtl/control_sequencer_step_decoder.sv | 110 +++++++++++
 rtl/control_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared definitions for the hardwired control unit.
//   - opcode values (IR[31:27])
//   - sequencer state encoding (RST, T0..T7, HALT)
//   - control vector bundle produced by the step decoder
//   - last_step(): final execute step of each opcode
package cpu_defs;

    localparam int          OPW    = 5;
    localparam logic [4:0]  ADD_OP = 5'b00011;

    localparam logic [OPW-1:0] OP_LDW  = 5'b00000;
    localparam logic [OPW-1:0] OP_LDWI = 5'b00001;
    localparam logic [OPW-1:0] OP_STW  = 5'b00010;
    localparam logic [OPW-1:0] OP_R_LO = 5'b00011;  // R-type range start (add)
    localparam logic [OPW-1:0] OP_R_HI = 5'b01010;  // R-type range end
    localparam logic [OPW-1:0] OP_I_LO = 5'b01011;  // immediate range start
    localparam logic [OPW-1:0] OP_I_HI = 5'b01101;  // immediate range end
    localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic [4:0] alu_op;
        logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out;
        logic inport_out, ba_out, c_out, r_out;
        logic mar_en, mdr_en, mdr_read, ir_en, y_en, zlow_in, zhigh_in;
        logic pc_en, hi_en, lo_en, outport_en, con_en, r_in, inc_pc, ram_write;
        logic gra, grb, grc, run;
    } ctrl_t;

    // Final step of each instruction; nop, halt and undefined opcodes end at T2.
    function automatic state_t last_step(input logic [OPW-1:0] op);
        state_t s;
        case (op) inside
            OP_LDW, OP_STW:                              s = S_T7;
            OP_LDWI, [OP_R_LO:OP_R_HI], [OP_I_LO:OP_I_HI]: s = S_T5;
            OP_MUL, OP_DIV, OP_BR:                       s = S_T6;
            OP_NEG, OP_NOT, OP_JAL:                      s = S_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:      s = S_T3;
            default:                                     s = S_T2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// step_decoder: combinational map from (state, opcode, branch flag) to the
// full datapath control vector. Everything not named for a step stays 0.
//   i_state        current sequencer step
//   i_opcode       IR[31:27]
//   i_branch_flag  CON flip-flop, gates PC load in branch T6
//   o_ctrl         control vector
module step_decoder
    import cpu_defs::*;
(
    input  state_t         i_state,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_branch_flag,
    output ctrl_t          o_ctrl
);

    // Decode one control word per step.
    always_comb begin
        o_ctrl     = '0;
        o_ctrl.run = (i_state != S_RST) && (i_state != S_HALT);
        case (i_state)
            S_T0: begin o_ctrl.pc_out = 1'b1; o_ctrl.mar_en = 1'b1; o_ctrl.inc_pc = 1'b1; o_ctrl.zlow_in = 1'b1; end
            S_T1: begin o_ctrl.zlow_out = 1'b1; o_ctrl.pc_en = 1'b1; o_ctrl.mdr_read = 1'b1; o_ctrl.mdr_en = 1'b1; end
            S_T2: begin o_ctrl.mdr_out = 1'b1; o_ctrl.ir_en = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (i_opcode) inside
                    OP_LDW, OP_LDWI, OP_STW: begin
                        case (i_state)
                            S_T3: begin o_ctrl.grb = 1'b1; o_ctrl.ba_out = 1'b1; o_ctrl.y_en = 1'b1; end
                            S_T4: begin o_ctrl.c_out = 1'b1; o_ctrl.zlow_in = 1'b1; o_ctrl.alu_op = ADD_OP; end
                            S_T5: begin
                                o_ctrl.zlow_out = 1'b1;
                                if (i_opcode == OP_LDWI) begin o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                                else                     begin o_ctrl.mar_en = 1'b1; end
                            end
                            S_T6: begin
                                if (i_opcode == OP_LDW)      begin o_ctrl.mdr_read = 1'b1; o_ctrl.mdr_en = 1'b1; end
                                else if (i_opcode == OP_STW) begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.mdr_en = 1'b1; end
                                else                         begin o_ctrl.mdr_en = 1'b0; end
                            end
                            S_T7: begin
                                if (i_opcode == OP_LDW) begin o_ctrl.mdr_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                                else                    begin o_ctrl.ram_write = (i_opcode == OP_STW); end
                            end
                            default: o_ctrl.alu_op = 5'd0;
                        endcase
                    end
                    [OP_R_LO:OP_R_HI], [OP_I_LO:OP_I_HI]: begin
                        case (i_state)
                            S_T3: begin o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.y_en = 1'b1; end
                            S_T4: begin
                                // R-type takes the second operand from Rc, immediates from C.
                                if (i_opcode <= OP_R_HI) begin o_ctrl.grc = 1'b1; o_ctrl.r_out = 1'b1; end
                                else                     begin o_ctrl.c_out = 1'b1; end
                                o_ctrl.alu_op = i_opcode; o_ctrl.zlow_in = 1'b1;
                            end
                            S_T5: begin o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                            default: o_ctrl.alu_op = 5'd0;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (i_state)
                            S_T3: begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.y_en = 1'b1; end
                            S_T4: begin o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.alu_op = i_opcode;
                                        o_ctrl.zhigh_in = 1'b1; o_ctrl.zlow_in = 1'b1; end
                            S_T5: begin o_ctrl.zlow_out = 1'b1; o_ctrl.lo_en = 1'b1; end
                            S_T6: begin o_ctrl.zhigh_out = 1'b1; o_ctrl.hi_en = 1'b1; end
                            default: o_ctrl.alu_op = 5'd0;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (i_state)
                            S_T3: begin o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.alu_op = i_opcode; o_ctrl.zlow_in = 1'b1; end
                            S_T4: begin o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                            default: o_ctrl.alu_op = 5'd0;
                        endcase
                    end
                    OP_BR: begin
                        case (i_state)
                            S_T3: begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.con_en = 1'b1; end
                            S_T4: begin o_ctrl.pc_out = 1'b1; o_ctrl.y_en = 1'b1; end
                            S_T5: begin o_ctrl.c_out = 1'b1; o_ctrl.alu_op = ADD_OP; o_ctrl.zlow_in = 1'b1; end
                            S_T6: begin o_ctrl.zlow_out = 1'b1; o_ctrl.pc_en = i_branch_flag; end
                            default: o_ctrl.alu_op = 5'd0;
                        endcase
                    end
                    OP_JR:   if (i_state == S_T3) begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.pc_en = 1'b1; end
                             else                 begin o_ctrl.pc_en = 1'b0; end
                    OP_JAL: begin
                        case (i_state)
                            S_T3: begin o_ctrl.pc_out = 1'b1; o_ctrl.grb = 1'b1; o_ctrl.r_in = 1'b1; end
                            S_T4: begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.pc_en = 1'b1; end
                            default: o_ctrl.alu_op = 5'd0;
                        endcase
                    end
                    OP_IN:   if (i_state == S_T3) begin o_ctrl.inport_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                             else                 begin o_ctrl.r_in = 1'b0; end
                    OP_OUT:  if (i_state == S_T3) begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.outport_en = 1'b1; end
                             else                 begin o_ctrl.r_out = 1'b0; end
                    OP_MFHI: if (i_state == S_T3) begin o_ctrl.hi_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                             else                 begin o_ctrl.r_in = 1'b0; end
                    OP_MFLO: if (i_state == S_T3) begin o_ctrl.lo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
                             else                 begin o_ctrl.r_in = 1'b0; end
                    default: o_ctrl.alu_op = 5'd0;
                endcase
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit stepping fetch (T0-T2) and
// execute (T3-T7) for every opcode. Holds only the step register and the
// next-step logic; control decoding lives in step_decoder.
//   Clock, Clear(async active-low)       clock / reset
//   IR, branch_flag, Stop                datapath feedback and halt request
//   Run, ALU_op, bus enables, loads, Gr* datapath control, one-for-one
module control_sequencer
    import cpu_defs::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        branch_flag,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  ALU_op,
    output logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout,
    output logic        InPortout, BAout, Cout, R_out,
    output logic        MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable,
    output logic        ZLowIn, ZHighIn, PC_enable, HI_enable, LO_enable,
    output logic        OutPort_enable, CON_enable, R_in, IncPC, RAM_write,
    output logic        Gra, Grb, Grc
);

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] w_opcode;
    ctrl_t          w_ctrl;

    assign w_opcode = IR[31:27];

    // Next step: advance, or at the instruction's last step return to T0 (or HALT).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_HALT: w_next = S_HALT;
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (r_state == last_step(w_opcode)) begin
                    w_next = ((w_opcode == OP_HALT) || Stop) ? S_HALT : S_T0;
                end else begin
                    w_next = state_t'(r_state + 4'd1);
                end
            end
            default: w_next = S_RST;
        endcase
    end

    // Step register; Clear aborts any instruction in flight.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    step_decoder u_step_decoder (
        .i_state       (r_state),
        .i_opcode      (w_opcode),
        .i_branch_flag (branch_flag),
        .o_ctrl        (w_ctrl)
    );

    assign Run            = w_ctrl.run;
    assign ALU_op         = w_ctrl.alu_op;
    assign PCout          = w_ctrl.pc_out;
    assign ZLowout        = w_ctrl.zlow_out;
    assign ZHighout       = w_ctrl.zhigh_out;
    assign MDRout         = w_ctrl.mdr_out;
    assign HIout          = w_ctrl.hi_out;
    assign LOout          = w_ctrl.lo_out;
    assign InPortout      = w_ctrl.inport_out;
    assign BAout          = w_ctrl.ba_out;
    assign Cout           = w_ctrl.c_out;
    assign R_out          = w_ctrl.r_out;
    assign MAR_enable     = w_ctrl.mar_en;
    assign MDR_enable     = w_ctrl.mdr_en;
    assign MDR_read       = w_ctrl.mdr_read;
    assign IR_enable      = w_ctrl.ir_en;
    assign Y_enable       = w_ctrl.y_en;
    assign ZLowIn         = w_ctrl.zlow_in;
    assign ZHighIn        = w_ctrl.zhigh_in;
    assign PC_enable      = w_ctrl.pc_en;
    assign HI_enable      = w_ctrl.hi_en;
    assign LO_enable      = w_ctrl.lo_en;
    assign OutPort_enable = w_ctrl.outport_en;
    assign CON_enable     = w_ctrl.con_en;
    assign R_in           = w_ctrl.r_in;
    assign IncPC          = w_ctrl.inc_pc;
    assign RAM_write      = w_ctrl.ram_write;
    assign Gra            = w_ctrl.gra;
    assign Grb            = w_ctrl.grb;
    assign Grc            = w_ctrl.grc;

endmodule
